// File: rtl/sprite_mover_pipe.sv
// Joystick-driven sprite renderer: per-frame clamped position FSM plus ROM-latency-matched pixel pipeline.
// Optional full-screen crosshair outside the sprite box when SPRITE_RETICLE_EN is defined.
module sprite_mover_pipe #(
   parameter int unsigned SCREEN_W  = 640,
   parameter int unsigned SCREEN_H  = 480,
   parameter int unsigned SPR_W     = 60,
   parameter int unsigned SPR_H     = 60,
   parameter int unsigned ADDR_W    = 12,
   parameter int unsigned ROM_LAT   = 1,
   parameter int unsigned TH_HI     = 3000,
   parameter int unsigned TH_MH     = 2100,
   parameter int unsigned TH_ML     = 1900,
   parameter int unsigned TH_LO     = 1000,
   parameter int unsigned SPD_FAST  = 6,
   parameter int unsigned SPD_SLOW  = 2,
   parameter bit          INV_X     = 1'b1,
   parameter bit          INV_Y     = 1'b0,
   parameter logic [11:0] KEY_COLOR = 12'h000
) (
   input  logic              clk25,
   input  logic              rst,
   input  logic [9:0]        x,
   input  logic [9:0]        y,
   input  logic              in_display,
   input  logic              hsync,
   input  logic              vsync,
   input  logic              frame,
   input  logic [11:0]       ch_x,
   input  logic [11:0]       ch_y,
   output logic [ADDR_W-1:0] sprite_addr,
   input  logic [11:0]       sprite_pixel,
   output logic [3:0]        vga_r,
   output logic [3:0]        vga_g,
   output logic [3:0]        vga_b,
   output logic              vga_hsync,
   output logic              vga_vsync,
   output logic [9:0]        pos_x,
   output logic [9:0]        pos_y,
   output logic              pos_upd
);

   localparam int unsigned MAX_X = SCREEN_W - SPR_W;
   localparam int unsigned MAX_Y = SCREEN_H - SPR_H;
   localparam logic [9:0] POS_X0 = 10'(MAX_X / 2);
   localparam logic [9:0] POS_Y0 = 10'(MAX_Y / 2);
   localparam logic signed [11:0] D_FAST = 12'(SPD_FAST);
   localparam logic signed [11:0] D_SLOW = 12'(SPD_SLOW);
   localparam logic [11:0] RET_COLOR = 12'h3DD;

   typedef enum logic [1:0] {IDLE, SAMPLE, APPLY} state_t;

   typedef struct packed {
      logic ret;
      logic in_spr;
      logic disp;
      logic hs;
      logic vs;
   } flags_t;

   state_t state, state_nx;
   logic [11:0] ch_x_q, ch_y_q;
   logic signed [11:0] dx, dy;

   // Dead-zone mapping of one raw ADC value to a signed per-frame step
   function automatic logic signed [11:0] zone_d(input logic [11:0] v, input bit inv);
      logic signed [11:0] d;
      if (v > 12'(TH_HI))      d = D_FAST;
      else if (v > 12'(TH_MH)) d = D_SLOW;
      else if (v > 12'(TH_ML)) d = 12'sd0;
      else if (v > 12'(TH_LO)) d = -D_SLOW;
      else                     d = -D_FAST;
      return inv ? -d : d;
   endfunction

   function automatic logic [9:0] clamp_add(input logic [9:0] p, input logic signed [11:0] d,
                                            input logic [9:0] maxv);
      logic signed [11:0] s;
      s = $signed({2'b00, p}) + d;
      if (s < 0)                            return 10'd0;
      else if (s > $signed({2'b00, maxv}))  return maxv;
      else                                  return s[9:0];
   endfunction

   always_ff @(posedge clk25) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (frame) state_nx = SAMPLE;
         SAMPLE:  state_nx = APPLY;
         APPLY:   state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Position datapath: capture, step, clamped write
   always_ff @(posedge clk25) begin
      if (rst) begin
         ch_x_q  <= '0;
         ch_y_q  <= '0;
         dx      <= '0;
         dy      <= '0;
         pos_x   <= POS_X0;
         pos_y   <= POS_Y0;
         pos_upd <= 1'b0;
      end else begin
         pos_upd <= 1'b0;
         if (state == IDLE && frame) begin
            ch_x_q <= ch_x;
            ch_y_q <= ch_y;
         end
         if (state == SAMPLE) begin
            dx <= zone_d(ch_x_q, INV_X);
            dy <= zone_d(ch_y_q, INV_Y);
         end
         if (state == APPLY) begin
            pos_x   <= clamp_add(pos_x, dx, 10'(MAX_X));
            pos_y   <= clamp_add(pos_y, dy, 10'(MAX_Y));
            pos_upd <= 1'b1;
         end
      end
   end

   logic [10:0] x_e, y_e, px_e, py_e;
   logic [9:0]  rel_x_c, rel_y_c;
   logic        in_spr_c, ret_c;
   logic [ADDR_W-1:0] addr_c;

   always_comb begin
      x_e      = {1'b0, x};
      y_e      = {1'b0, y};
      px_e     = {1'b0, pos_x};
      py_e     = {1'b0, pos_y};
      rel_x_c  = x - pos_x;
      rel_y_c  = y - pos_y;
      in_spr_c = (x_e >= px_e) && (x_e < px_e + 11'(SPR_W)) &&
                 (y_e >= py_e) && (y_e < py_e + 11'(SPR_H));
      addr_c   = in_spr_c ? ADDR_W'(rel_y_c) * ADDR_W'(SPR_W) + ADDR_W'(rel_x_c) : '0;
`ifdef SPRITE_RETICLE_EN
      ret_c    = !in_spr_c && ((x_e == px_e + 11'(SPR_W / 2)) || (y_e == py_e + 11'(SPR_H / 2)));
`else
      ret_c    = 1'b0;
`endif
   end

   // S0 plus ROM_LAT flag stages so flags meet the ROM data
   flags_t dl [ROM_LAT+1];

   always_ff @(posedge clk25) begin
      if (rst) begin
         sprite_addr <= '0;
         for (int i = 0; i <= int'(ROM_LAT); i++) dl[i] <= '0;
      end else begin
         sprite_addr <= addr_c;
         dl[0]       <= '{ret: ret_c, in_spr: in_spr_c, disp: in_display, hs: hsync, vs: vsync};
         for (int i = 1; i <= int'(ROM_LAT); i++) dl[i] <= dl[i-1];
      end
   end

   flags_t      fl_c;
   logic [11:0] color_c;

   always_comb begin
      fl_c    = dl[ROM_LAT];
      color_c = 12'h000;
      if (!fl_c.disp)                                     color_c = 12'h000;
      else if (fl_c.in_spr && sprite_pixel != KEY_COLOR)  color_c = sprite_pixel;
      else if (fl_c.ret)                                  color_c = RET_COLOR;
   end

   always_ff @(posedge clk25) begin
      if (rst) begin
         vga_r     <= '0;
         vga_g     <= '0;
         vga_b     <= '0;
         vga_hsync <= 1'b0;
         vga_vsync <= 1'b0;
      end else begin
         vga_r     <= color_c[11:8];
         vga_g     <= color_c[7:4];
         vga_b     <= color_c[3:0];
         vga_hsync <= fl_c.hs;
         vga_vsync <= fl_c.vs;
      end
   end

endmodule

// File: tb/tb_sprite_mover_pipe.sv
// Scoreboard bench for sprite_mover_pipe: timestamped expectation queues filled by stimulus, drained by a monitor.
module tb_sprite_mover_pipe;

   localparam int ROM_LAT = 1;
   localparam int LAT     = ROM_LAT + 2;
   localparam int SW      = 60;
   localparam int SH      = 60;
   localparam int MAX_X   = 580;
   localparam int MAX_Y   = 420;
   localparam int CX      = 290;
   localparam int CY      = 210;

   logic        clk25 = 1'b0;
   logic        rst = 1'b1;
   logic [9:0]  x = '0, y = '0;
   logic        in_display = 1'b0, hsync = 1'b0, vsync = 1'b0, frame = 1'b0;
   logic [11:0] ch_x = 12'd2000, ch_y = 12'd2000;
   logic [11:0] sprite_addr;
   logic [11:0] sprite_pixel = '0;
   logic [3:0]  vga_r, vga_g, vga_b;
   logic        vga_hsync, vga_vsync;
   logic [9:0]  pos_x, pos_y;
   logic        pos_upd;

   sprite_mover_pipe #(.ROM_LAT(ROM_LAT)) dut (
      .clk25(clk25), .rst(rst), .x(x), .y(y), .in_display(in_display),
      .hsync(hsync), .vsync(vsync), .frame(frame), .ch_x(ch_x), .ch_y(ch_y),
      .sprite_addr(sprite_addr), .sprite_pixel(sprite_pixel),
      .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
      .vga_hsync(vga_hsync), .vga_vsync(vga_vsync),
      .pos_x(pos_x), .pos_y(pos_y), .pos_upd(pos_upd)
   );

   always #20 clk25 = ~clk25;

   int cyc = 0;
   always @(posedge clk25) cyc <= cyc + 1;

   function automatic logic [11:0] rom(input logic [11:0] a);
      if (a == 12'd0)   return 12'hF00;
      if (a % 7 == 0)   return 12'h000;
      return 12'(a * 37 + 5) ^ 12'h5A5;
   endfunction

   // One-cycle-latency ROM model
   always @(posedge clk25) sprite_pixel <= rom(sprite_addr);

   typedef struct { int due; int px; int py; } pos_exp_t;
   typedef struct { int due; logic [11:0] col; logic hs; logic vs; } pix_exp_t;
   typedef struct { int due; int addr; } addr_exp_t;
   pos_exp_t  pq[$];
   pix_exp_t  xq[$];
   addr_exp_t aq[$];

   int errors = 0, checks = 0, upd_cnt = 0;
   int mpx = CX, mpy = CY, last_acc = -100;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
      end
   endtask

   function automatic int zone(input int v);
      if (v > 3000) return 6;
      if (v > 2100) return 2;
      if (v > 1900) return 0;
      if (v > 1000) return -2;
      return -6;
   endfunction

   function automatic int clampm(input int v, input int hi);
      return (v < 0) ? 0 : (v > hi) ? hi : v;
   endfunction

   // Monitor: drains expectations whenever the DUT presents them
   always @(negedge clk25) begin
      if (pos_upd) begin
         upd_cnt++;
         if (pq.size() == 0) begin
            check("pos_upd_unexpected", 1, 0);
         end else begin
            pos_exp_t e;
            e = pq.pop_front();
            check("pos_upd_time", cyc, e.due);
            check("pos_x", int'(pos_x), e.px);
            check("pos_y", int'(pos_y), e.py);
            check("pos_in_range", int'(pos_x <= 10'(MAX_X) && pos_y <= 10'(MAX_Y)), 1);
         end
      end
      if (pq.size() > 0 && pq[0].due < cyc) begin
         check("pos_upd_missing", 0, 1);
         void'(pq.pop_front());
      end
      while (aq.size() > 0 && aq[0].due == cyc) begin
         addr_exp_t a;
         a = aq.pop_front();
         check("sprite_addr", int'(sprite_addr), a.addr);
      end
      while (xq.size() > 0 && xq[0].due == cyc) begin
         pix_exp_t p;
         p = xq.pop_front();
         check("vga_rgb", int'({vga_r, vga_g, vga_b}), int'(p.col));
         check("vga_hsync", int'(vga_hsync), int'(p.hs));
         check("vga_vsync", int'(vga_vsync), int'(p.vs));
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk25);
         frame = 1'b0;
      end
   endtask

   task automatic do_reset(input int n);
      @(negedge clk25);
      rst = 1'b1; frame = 1'b0; in_display = 1'b0; hsync = 1'b0; vsync = 1'b0;
      pq.delete(); xq.delete(); aq.delete();
      mpx = CX; mpy = CY; last_acc = -100;
      repeat (n) @(negedge clk25);
      rst = 1'b0;
   endtask

   // Drive frame for one cycle; model accepts it only when the mover is idle
   task automatic frame_cycle(input int cx, input int cy);
      @(negedge clk25);
      frame = 1'b1; ch_x = 12'(cx); ch_y = 12'(cy);
      if (cyc + 1 > last_acc + 2) begin
         last_acc = cyc + 1;
         mpx = clampm(mpx - zone(cx), MAX_X);
         mpy = clampm(mpy + zone(cy), MAX_Y);
         pq.push_back('{cyc + 3, mpx, mpy});
      end
   endtask

   task automatic pix(input int px, input int py, input bit disp, input bit hs, input bit vs);
      bit in, ret;
      int a;
      logic [11:0] d, col;
      @(negedge clk25);
      frame = 1'b0;
      x = 10'(px); y = 10'(py); in_display = disp; hsync = hs; vsync = vs;
      in  = px >= mpx && px < mpx + SW && py >= mpy && py < mpy + SH;
      a   = in ? (py - mpy) * SW + (px - mpx) : 0;
      d   = rom(12'(a));
`ifdef SPRITE_RETICLE_EN
      ret = !in && (px == mpx + SW / 2 || py == mpy + SH / 2);
`else
      ret = 1'b0;
`endif
      if (!disp)                 col = 12'h000;
      else if (in && d != 0)     col = d;
      else if (ret)              col = 12'h3DD;
      else                       col = 12'h000;
      aq.push_back('{cyc + 1, a});
      xq.push_back('{cyc + LAT, col, hs, vs});
   endtask

   initial begin
      int base;
      repeat (3) @(negedge clk25);
      check("rst_vga_rgb", int'({vga_r, vga_g, vga_b}), 0);
      check("rst_vga_hsync", int'(vga_hsync), 0);
      check("rst_vga_vsync", int'(vga_vsync), 0);
      check("rst_sprite_addr", int'(sprite_addr), 0);
      check("rst_pos_upd", int'(pos_upd), 0);
      check("rst_pos_x", int'(pos_x), CX);
      check("rst_pos_y", int'(pos_y), CY);
      rst = 1'b0;

      // Full-right stick with inverted X moves left by the fast step
      frame_cycle(4095, 2000);
      idle(6);
      check("fast_left_pos_x", int'(pos_x), 284);
      check("fast_left_pos_y", int'(pos_y), 210);

      // Centred stick: five updates, no motion
      do_reset(2);
      base = upd_cnt;
      repeat (5) begin frame_cycle(2000, 2000); idle(4); end
      idle(3);
      check("dead_zone_upd_count", upd_cnt - base, 5);
      check("dead_zone_pos_x", int'(pos_x), CX);
      check("dead_zone_pos_y", int'(pos_y), CY);

      // Clamp at both ends
      repeat (50) begin frame_cycle(4095, 2000); idle(3); end
      idle(3);
      check("clamp_pos_x_zero", int'(pos_x), 0);
      repeat (50) begin frame_cycle(2000, 4095); idle(3); end
      idle(3);
      check("clamp_pos_y_max", int'(pos_y), MAX_Y);

      // Reset while in SAMPLE discards the update
      do_reset(2);
      frame_cycle(4095, 0);
      @(negedge clk25);
      frame = 1'b0; rst = 1'b1;
      pq.delete(); mpx = CX; mpy = CY; last_acc = -100;
      @(negedge clk25);
      rst = 1'b0;
      idle(5);
      check("abort_pos_x", int'(pos_x), CX);
      check("abort_pos_y", int'(pos_y), CY);
      frame_cycle(4095, 4095);
      idle(5);

      // Random frames, including ones that land while busy
      repeat (120) begin
         frame_cycle(int'($urandom_range(4095, 0)), int'($urandom_range(4095, 0)));
         idle(int'($urandom_range(4, 0)));
      end
      idle(6);

      // Pixel pipeline from the centred position
      do_reset(2);
      pix(290, 210, 1, 1, 0);
      pix(297, 210, 1, 0, 1);
      pix(320, 100, 1, 0, 0);
      pix(100, 240, 1, 1, 1);
      pix(349, 269, 1, 0, 0);
      pix(350, 210, 1, 0, 0);
      pix(290, 270, 1, 0, 0);
      pix(300, 220, 0, 1, 0);
      repeat (400) begin
         if ($urandom_range(3, 0) == 0)
            pix(int'($urandom_range(1023, 0)), int'($urandom_range(1023, 0)),
                1'($urandom_range(3, 0) != 0), 1'($urandom), 1'($urandom));
         else
            pix(mpx - 10 + int'($urandom_range(80, 0)), mpy - 10 + int'($urandom_range(80, 0)),
                1'($urandom_range(3, 0) != 0), 1'($urandom), 1'($urandom));
      end
      idle(LAT + 3);

      check("pos_queue_drained", pq.size(), 0);
      check("pix_queue_drained", xq.size(), 0);
      check("addr_queue_drained", aq.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
